// File: rtl/vs_triangle_sequencer.sv
// Vertex-shading sequencer: issues three SRAM vertex reads per triangle, gathers the
// shaded results into three slots and presents each triangle over valid/ready.
module vs_triangle_sequencer #(
  parameter int ADDR_W   = 20,
  parameter int PIPE_LAT = 12,
  parameter int SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_tri,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rd_en,
  output logic              vs_in_valid,
  input  logic              vs_out_valid,
  input  logic [20:0]       vs_depth,
  input  logic [23:0]       vs_color,
  input  logic [11:0]       vs_sx,
  input  logic [11:0]       vs_sy,
  output logic              tri_valid,
  input  logic              tri_ready,
  output logic [20:0]       vertice1_depth_update,
  output logic [20:0]       vertice2_depth_update,
  output logic [20:0]       vertice3_depth_update,
  output logic [23:0]       vertice1_color_update,
  output logic [23:0]       vertice2_color_update,
  output logic [23:0]       vertice3_color_update,
  output logic [11:0]       screen_x1_update,
  output logic [11:0]       screen_y1_update,
  output logic [11:0]       screen_x2_update,
  output logic [11:0]       screen_y2_update,
  output logic [11:0]       screen_x3_update,
  output logic [11:0]       screen_y3_update,
  output logic [ADDR_W-1:0] tri_index,
  output logic              busy,
  output logic              done,
  output logic              err_unexpected
);

  if (PIPE_LAT < 1 || SRAM_LAT < 1) begin : g_param_check
    $error("vs_triangle_sequencer: PIPE_LAT and SRAM_LAT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_num;
  logic [ADDR_W-1:0]   r_t;
  logic [1:0]          r_k;
  logic [1:0]          r_cnt;
  logic                r_err;
  logic                r_armed;
  logic [SRAM_LAT-1:0] r_rd_dly;
  logic [20:0]         r_depth [3];
  logic [23:0]         r_color [3];
  logic [11:0]         r_sx    [3];
  logic [11:0]         r_sy    [3];

  logic w_start_acc;
  logic w_res_acc;
  logic w_last_tri;
  logic w_spurious;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_res_acc   = (r_state == S_WAIT) && vs_out_valid;
  assign w_last_tri  = (r_t + ADDR_W'(1)) == r_num;
  // Results still draining from a frame aborted by reset are indistinguishable from
  // strays, so nothing is flagged until a frame has been started since reset.
  assign w_spurious  = vs_out_valid && r_armed && (r_state != S_WAIT);

  always_ff @(posedge clk) begin
    if (!srst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (num_tri == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:   if (r_k == 2'd2) w_next = S_WAIT;
      S_WAIT:    if (vs_out_valid && r_cnt == 2'd2) w_next = S_PRESENT;
      S_PRESENT: if (tri_ready) w_next = w_last_tri ? S_FINISH : S_ISSUE;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sram_rd_en = 1'b0;
    tri_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_ISSUE:   begin sram_rd_en = 1'b1; busy = 1'b1; end
      S_WAIT:    busy = 1'b1;
      S_PRESENT: begin tri_valid = 1'b1; busy = 1'b1; end
      S_FINISH:  begin done = 1'b1; busy = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_addr   <= '0;
      r_num    <= '0;
      r_t      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_armed  <= 1'b0;
      r_rd_dly <= '0;
      r_depth  <= '{default: '0};
      r_color  <= '{default: '0};
      r_sx     <= '{default: '0};
      r_sy     <= '{default: '0};
    end else begin
      r_rd_dly <= SRAM_LAT'({r_rd_dly, sram_rd_en});
      if (w_start_acc) begin
        r_addr  <= base_addr;
        r_num   <= num_tri;
        r_t     <= '0;
        r_k     <= '0;
        r_cnt   <= '0;
        r_err   <= 1'b0;
        r_armed <= 1'b1;
      end
      // Running address: after three issues it already points at the next triangle.
      if (r_state == S_ISSUE) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_k    <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
      end
      if (w_res_acc) begin
        r_depth[r_cnt] <= vs_depth;
        r_color[r_cnt] <= vs_color;
        r_sx[r_cnt]    <= vs_sx;
        r_sy[r_cnt]    <= vs_sy;
        r_cnt          <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
      end
      if (r_state == S_PRESENT && tri_ready) r_t <= r_t + ADDR_W'(1);
      if (w_spurious) r_err <= 1'b1;
    end
  end

  assign sram_addr             = r_addr;
  assign vs_in_valid           = r_rd_dly[SRAM_LAT-1];
  assign tri_index             = r_t;
  assign err_unexpected        = r_err;
  assign vertice1_depth_update = r_depth[0];
  assign vertice2_depth_update = r_depth[1];
  assign vertice3_depth_update = r_depth[2];
  assign vertice1_color_update = r_color[0];
  assign vertice2_color_update = r_color[1];
  assign vertice3_color_update = r_color[2];
  assign screen_x1_update      = r_sx[0];
  assign screen_y1_update      = r_sy[0];
  assign screen_x2_update      = r_sx[1];
  assign screen_y2_update      = r_sy[1];
  assign screen_x3_update      = r_sx[2];
  assign screen_y3_update      = r_sy[2];

endmodule
